// File: rtl/text_pkg.sv
// Shared constants and types for the text cursor sequencer: character code map,
// glyph/screen geometry and the slot FSM state encoding.
package text_pkg;

    localparam int CODE_W = 6;

    localparam logic [CODE_W-1:0] LET_MAX_GLYPH = 6'd37;
    localparam logic [CODE_W-1:0] LET_BLANK     = 6'd38;
    localparam logic [CODE_W-1:0] CODE_NL       = 6'd39;
    localparam logic [CODE_W-1:0] CODE_HOME     = 6'd40;

    localparam int GLYPH_W  = 7;
    localparam int GLYPH_H  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } seq_state_e;

    // Row advance with wrap back to the top of the screen.
    function automatic logic [5:0] next_row(input logic [5:0] row, input logic [5:0] row_last);
        logic [5:0] nxt;
        if (row == row_last) begin
            nxt = 6'd0;
        end else begin
            nxt = row + 6'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous character FIFO; pointers carry an extra MSB so full and empty
// are distinguished without a separate count register.
module char_fifo
    import text_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [CODE_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [CODE_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_level
);

    logic [CODE_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_wr;
    logic              w_rd;

    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;

    // Storage and pointer update; reset clears contents as well as pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/text_cursor_sequencer.sv
// Feeds the letter writer one character per let_done slot, tracking the text
// cursor with column/row wrap plus newline and home control codes.
module text_cursor_sequencer
    import text_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PITCH_X    = 8,
    parameter int PITCH_Y    = 12,
    parameter int COLS       = 80,
    parameter int ROWS       = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_let_done,
    output logic [CODE_W-1:0] o_let,
    output logic [9:0]        o_x_pos,
    output logic [8:0]        o_y_pos,
    output logic [6:0]        o_cursor_col,
    output logic [5:0]        o_cursor_row,
    output logic [3:0]        o_fifo_level,
    output logic              o_bad_code
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

    logic              r_s1, r_s2, r_s3;
    logic [CODE_W-1:0] r_let;
    logic [9:0]        r_x;
    logic [8:0]        r_y;
    logic [6:0]        r_col;
    logic [5:0]        r_row;
    logic              r_bad;
    seq_state_e        r_state;

    logic              w_bnd;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_level;
    logic [CODE_W-1:0] w_rd_code;
    logic [CODE_W-1:0] w_let_nxt;
    logic [6:0]        w_col_nxt;
    logic [5:0]        w_row_nxt;
    logic              w_bad_nxt;
    seq_state_e        w_state_nxt;

    char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (i_valid && !w_full),
        .i_wr_data (i_code),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_code),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    assign w_bnd        = r_s2 && !r_s3;
    assign w_pop        = w_bnd && !w_empty;
    assign o_ready      = !w_full;
    assign o_fifo_level = 4'(w_level);
    assign o_let        = r_let;
    assign o_x_pos      = r_x;
    assign o_y_pos      = r_y;
    assign o_cursor_col = r_col;
    assign o_cursor_row = r_row;
    assign o_bad_code   = r_bad;

    // Decode the popped entry into the next letter and cursor position.
    always_comb begin
        w_let_nxt = LET_BLANK;
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        w_bad_nxt = 1'b0;
        if (w_pop) begin
            if (w_rd_code <= LET_BLANK) begin
                w_let_nxt = w_rd_code;
                if (r_col < COL_LAST) begin
                    w_col_nxt = r_col + 7'd1;
                end else begin
                    w_col_nxt = 7'd0;
                    w_row_nxt = next_row(r_row, ROW_LAST);
                end
            end else if (w_rd_code == CODE_NL) begin
                w_col_nxt = 7'd0;
                w_row_nxt = next_row(r_row, ROW_LAST);
            end else if (w_rd_code == CODE_HOME) begin
                w_col_nxt = 7'd0;
                w_row_nxt = 6'd0;
            end else begin
                w_bad_nxt = 1'b1;
            end
        end else begin
            w_let_nxt = LET_BLANK;
        end
    end

    // Slot FSM next state: debug visibility of whether the slot holds a pop.
    always_comb begin
        w_state_nxt = r_state;
        if (w_bnd) begin
            w_state_nxt = w_pop ? ST_DRAW : ST_IDLE;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // let_done synchronizer plus edge-detect delay stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_let_done;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Slot registers: only a boundary loads them; bad_code lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_let   <= LET_BLANK;
            r_x     <= 10'd0;
            r_y     <= 9'd0;
            r_col   <= 7'd0;
            r_row   <= 6'd0;
            r_bad   <= 1'b0;
            r_state <= ST_IDLE;
        end else if (w_bnd) begin
            r_let   <= w_let_nxt;
            r_x     <= 10'(r_col * PITCH_X);
            r_y     <= 9'(r_row * PITCH_Y);
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_bad   <= w_bad_nxt;
            r_state <= w_state_nxt;
        end else begin
            r_bad   <= 1'b0;
        end
    end

endmodule
